// File: rtl/mipi_rx_raw_depacker_multi.sv
// RAW8/10/12/14 CSI payload depacker: LANES bytes in, four MSB-aligned pixels out per beat.
// Optional pixel counter output enabled by defining MIPI_RX_DEPACKER_PIXCNT_EN.
module mipi_rx_raw_depacker_multi #(
   parameter int unsigned LANES = 4,
   parameter int unsigned PIX_W = 14,
   parameter int unsigned CNT_W = 16
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 data_valid_i,
   input  logic [LANES*8-1:0]   data_i,
   input  logic [7:0]           data_type_i,
   output logic                 output_valid_o,
   output logic [4*PIX_W-1:0]   output_o,
   output logic                 err_residue_o,
   output logic                 err_type_o
`ifdef MIPI_RX_DEPACKER_PIXCNT_EN
   ,
   output logic [CNT_W-1:0]     pixel_count_o
`endif
);

   localparam int unsigned DW    = LANES * 8;
   localparam int unsigned ACC_B = 10;
   localparam int unsigned ACC_W = ACC_B * 8;
   localparam int unsigned CW    = 4;
   localparam int unsigned OW    = 4 * PIX_W;

   localparam logic [7:0] DT_RAW8  = 8'h2A;
   localparam logic [7:0] DT_RAW10 = 8'h2B;
   localparam logic [7:0] DT_RAW12 = 8'h2C;
   localparam logic [7:0] DT_RAW14 = 8'h2D;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_SKIP} state_e;

   state_e            state_q, state_d;
   logic              block_q;
   logic              vld_q, vld_prev_q;
   logic [DW-1:0]     data_q;
   logic [7:0]        dtype_q;
   logic [7:0]        pkt_type_q, pkt_type_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [OW-1:0]     out_q, out_d;
   logic              ovld_q, ovld_d;
   logic              err_res_q, err_res_d;
   logic              err_type_q, err_type_d;

   logic              start_c, supported_c, accept_c, emit_c;
   logic [7:0]        typ_c;
   logic [CW-1:0]     g_c, sum_c;
   logic [ACC_W-1:0]  comb_c;
   logic [OW-1:0]     pix_c;
   logic [7:0]        b_c [7];
   logic [13:0]       p14_c [4];
   logic [23:0]       w14_c;

   // Type in force: the freshly registered one at packet start, otherwise the latched one.
   always_comb begin
      start_c = (state_q == S_IDLE) && vld_q && !vld_prev_q;
      typ_c   = (state_q == S_IDLE) ? dtype_q : pkt_type_q;
      supported_c = 1'b1;
      case (typ_c)
         DT_RAW8:  g_c = CW'(4);
         DT_RAW10: g_c = CW'(5);
         DT_RAW12: g_c = CW'(6);
         DT_RAW14: g_c = CW'(7);
         default: begin
            g_c = CW'(7);
            supported_c = 1'b0;
         end
      endcase
      sum_c  = cnt_q + CW'(LANES);
      comb_c = acc_q | (ACC_W'(data_q) << {cnt_q, 3'b000});
   end

   // Unpack the oldest group of the combined byte stream.
   always_comb begin
      for (int i = 0; i < 7; i++) b_c[i] = comb_c[8*i +: 8];
      w14_c = {b_c[6], b_c[5], b_c[4]};
      for (int n = 0; n < 4; n++) p14_c[n] = '0;
      case (typ_c)
         DT_RAW8:  for (int n = 0; n < 4; n++) p14_c[n] = {b_c[n], 6'd0};
         DT_RAW10: for (int n = 0; n < 4; n++) p14_c[n] = {b_c[n], b_c[4][2*n +: 2], 4'd0};
         DT_RAW12: begin
            p14_c[0] = {b_c[0], b_c[2][3:0], 2'd0};
            p14_c[1] = {b_c[1], b_c[2][7:4], 2'd0};
            p14_c[2] = {b_c[3], b_c[5][3:0], 2'd0};
            p14_c[3] = {b_c[4], b_c[5][7:4], 2'd0};
         end
         DT_RAW14: for (int n = 0; n < 4; n++) p14_c[n] = {b_c[n], w14_c[6*n +: 6]};
         default: ;
      endcase
      pix_c = '0;
      for (int n = 0; n < 4; n++)
         pix_c[(3-n)*PIX_W +: PIX_W] = PIX_W'(p14_c[n]) << (PIX_W - 14);
   end

   // Next-state, accumulator and output logic.
   always_comb begin
      state_d    = state_q;
      pkt_type_d = pkt_type_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      out_d      = out_q;
      ovld_d     = 1'b0;
      err_res_d  = 1'b0;
      err_type_d = 1'b0;
      accept_c   = 1'b0;
      emit_c     = 1'b0;
      case (state_q)
         S_IDLE: begin
            acc_d = '0;
            cnt_d = '0;
            if (start_c) begin
               pkt_type_d = dtype_q;
               if (supported_c) begin
                  state_d  = S_RUN;
                  accept_c = 1'b1;
               end else begin
                  state_d    = S_SKIP;
                  err_type_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (vld_q) begin
               accept_c = 1'b1;
            end else begin
               state_d   = S_IDLE;
               err_res_d = (cnt_q != '0);
               acc_d     = '0;
               cnt_d     = '0;
            end
         end
         S_SKIP: begin
            acc_d = '0;
            cnt_d = '0;
            if (!vld_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (accept_c) begin
         if (sum_c >= g_c) begin
            emit_c = 1'b1;
            acc_d  = comb_c >> {g_c, 3'b000};
            cnt_d  = sum_c - g_c;
            out_d  = pix_c;
            ovld_d = 1'b1;
         end else begin
            acc_d = comb_c;
            cnt_d = sum_c;
         end
      end
   end

   // Valid stays masked after reset until the source drops valid once.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         block_q    <= 1'b1;
         vld_q      <= 1'b0;
         vld_prev_q <= 1'b0;
         data_q     <= '0;
         dtype_q    <= '0;
      end else begin
         if (!data_valid_i) block_q <= 1'b0;
         vld_q      <= data_valid_i && !block_q;
         vld_prev_q <= vld_q;
         data_q     <= data_i;
         dtype_q    <= data_type_i;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         pkt_type_q <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         out_q      <= '0;
         ovld_q     <= 1'b0;
         err_res_q  <= 1'b0;
         err_type_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pkt_type_q <= pkt_type_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         out_q      <= out_d;
         ovld_q     <= ovld_d;
         err_res_q  <= err_res_d;
         err_type_q <= err_type_d;
      end
   end

   assign output_valid_o = ovld_q;
   assign output_o       = out_q;
   assign err_residue_o  = err_res_q;
   assign err_type_o     = err_type_q;

`ifdef MIPI_RX_DEPACKER_PIXCNT_EN
   logic [CNT_W-1:0] pixcnt_q, pixcnt_d;

   // Cleared at packet start, +4 per emitted beat, held after packet end.
   always_comb begin
      pixcnt_d = (start_c ? '0 : pixcnt_q) + (emit_c ? CNT_W'(4) : '0);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) pixcnt_q <= '0;
      else         pixcnt_q <= pixcnt_d;
   end

   assign pixel_count_o = pixcnt_q;
`else
   logic [CNT_W-1:0] unused_pixcnt;
   assign unused_pixcnt = '0;
`endif

endmodule

// File: tb/tb_mipi_rx_raw_depacker_multi.sv
// Directed bench for mipi_rx_raw_depacker_multi (LANES=4, PIX_W=14).
module tb_mipi_rx_raw_depacker_multi;

   localparam int unsigned LANES = 4;
   localparam int unsigned PIX_W = 14;
   localparam int unsigned CNT_W = 16;

   logic                clk_i = 1'b0;
   logic                reset_i;
   logic                data_valid_i;
   logic [LANES*8-1:0]  data_i;
   logic [7:0]          data_type_i;
   logic                output_valid_o;
   logic [4*PIX_W-1:0]  output_o;
   logic                err_residue_o;
   logic                err_type_o;
`ifdef MIPI_RX_DEPACKER_PIXCNT_EN
   logic [CNT_W-1:0]    pixel_count_o;
`endif

   mipi_rx_raw_depacker_multi #(.LANES(LANES), .PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .data_valid_i   (data_valid_i),
      .data_i         (data_i),
      .data_type_i    (data_type_i),
      .output_valid_o (output_valid_o),
      .output_o       (output_o),
      .err_residue_o  (err_residue_o),
      .err_type_o     (err_type_o)
`ifdef MIPI_RX_DEPACKER_PIXCNT_EN
      ,
      .pixel_count_o  (pixel_count_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input logic v, input logic [31:0] d, input logic [7:0] t);
      data_valid_i = v;
      data_i       = d;
      data_type_i  = t;
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [55:0] pk(input logic [13:0] a, input logic [13:0] b,
                                      input logic [13:0] c, input logic [13:0] d);
      return {a, b, c, d};
   endfunction

   logic [55:0] exp_raw10, exp_raw12, exp_raw14;
   logic [31:0] raw14_beats [7];
   logic [7:0]  bt [4];
   logic [31:0] beat;
   int          ov_cnt, er_cnt;

   initial begin
      exp_raw10 = pk(14'h0440, 14'h0890, 14'h0CE0, 14'h1130);
      exp_raw12 = pk(14'h2AC4, 14'h3348, 14'h3BCC, 14'h0050);
      exp_raw14 = pk(14'h0401, 14'h0802, 14'h0C03, 14'h1004);
      raw14_beats[0] = 32'h40302010; raw14_beats[1] = 32'h10103081;
      raw14_beats[2] = 32'h81403020; raw14_beats[3] = 32'h20101030;
      raw14_beats[4] = 32'h30814030; raw14_beats[5] = 32'h30201010;
      raw14_beats[6] = 32'h10308140;

      reset_i = 1'b1; data_valid_i = 1'b0; data_i = '0; data_type_i = '0;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_valid", output_valid_o, 0);
      check("rst_out", output_o, 0);
      check("rst_err_res", err_residue_o, 0);
      check("rst_err_type", err_type_o, 0);
      reset_i = 1'b0;
      step(0, 0, 0);

      // RAW10 then RAW12 with a one-cycle valid gap
      step(1, 32'h44332211, 8'h2B);
      step(1, 32'h776655E4, 8'h2B);
      check("raw10_partial_novalid", output_valid_o, 0);
      step(0, 0, 8'h2B);
      check("raw10_valid", output_valid_o, 1);
      check("raw10_pixels", output_o, exp_raw10);
      check("raw10_no_res_yet", err_residue_o, 0);
      step(1, 32'hEF21CDAB, 8'h2C);
      check("raw10_valid_1cyc", output_valid_o, 0);
      check("raw10_residue", err_residue_o, 1);
      step(1, 32'h99884301, 8'h2C);
      check("raw10_residue_1cyc", err_residue_o, 0);
      check("raw12_partial_novalid", output_valid_o, 0);
      step(0, 0, 0);
      check("raw12_valid", output_valid_o, 1);
      check("raw12_pixels", output_o, exp_raw12);
      step(0, 0, 0);
      check("raw12_single_beat", output_valid_o, 0);
      check("raw12_residue", err_residue_o, 1);
      step(0, 0, 0);
      check("raw12_residue_1cyc", err_residue_o, 0);

      // RAW8: 8 beats -> 8 consecutive output beats
      for (int j = 0; j < 10; j++) begin
         for (int n = 0; n < 4; n++) bt[n] = 8'(8'h10 + 4*j + n);
         beat = {bt[3], bt[2], bt[1], bt[0]};
         step(j < 8, beat, 8'h2A);
         if (j >= 1 && j <= 8) begin
            for (int n = 0; n < 4; n++) bt[n] = 8'(8'h10 + 4*(j-1) + n);
            check($sformatf("raw8_valid_%0d", j-1), output_valid_o, 1);
            check($sformatf("raw8_pix_%0d", j-1), output_o,
                  pk({bt[0], 6'd0}, {bt[1], 6'd0}, {bt[2], 6'd0}, {bt[3], 6'd0}));
         end
      end
      check("raw8_end_novalid", output_valid_o, 0);
      check("raw8_end_nores", err_residue_o, 0);
`ifdef MIPI_RX_DEPACKER_PIXCNT_EN
      check("raw8_pixcnt", pixel_count_o, 32);
`endif

      // RAW14: 28 bytes -> exactly 4 beats, emitted after beats 2,4,6,7
      ov_cnt = 0; er_cnt = 0;
      for (int j = 0; j < 11; j++) begin
         step(j < 7, (j < 7) ? raw14_beats[j] : 32'h0, 8'h2D);
         check($sformatf("raw14_valid_c%0d", j), output_valid_o,
               (j == 2 || j == 4 || j == 6 || j == 7) ? 1 : 0);
         if (output_valid_o) begin
            ov_cnt++;
            check($sformatf("raw14_pix_c%0d", j), output_o, exp_raw14);
         end
         if (err_residue_o) er_cnt++;
      end
      check("raw14_beats", ov_cnt, 4);
      check("raw14_nores", er_cnt, 0);
`ifdef MIPI_RX_DEPACKER_PIXCNT_EN
      check("raw14_pixcnt", pixel_count_o, 16);
`endif

      // Unsupported type
      for (int j = 0; j < 6; j++) begin
         step(j < 3, 32'hDEADBEEF, 8'h1E);
         check($sformatf("badtype_novalid_c%0d", j), output_valid_o, 0);
         check($sformatf("badtype_err_c%0d", j), err_type_o, (j == 1) ? 1 : 0);
         check($sformatf("badtype_nores_c%0d", j), err_residue_o, 0);
      end
`ifdef MIPI_RX_DEPACKER_PIXCNT_EN
      check("badtype_pixcnt", pixel_count_o, 0);
`endif

      // Reset in the middle of a RAW12 packet
      step(1, 32'hEF21CDAB, 8'h2C);
      step(1, 32'h99884301, 8'h2C);
      step(1, 32'h11111111, 8'h2C);
      check("rst_mid_pre_valid", output_valid_o, 1);
      #2 reset_i = 1'b1;
      #1;
      check("rst_mid_valid", output_valid_o, 0);
      check("rst_mid_out", output_o, 0);
      check("rst_mid_err", {err_residue_o, err_type_o}, 0);
      @(posedge clk_i);
      #1 reset_i = 1'b0;
      for (int j = 0; j < 4; j++) begin
         step(1, 32'h11111111, 8'h2C);
         check($sformatf("rst_hold_novalid_c%0d", j), output_valid_o, 0);
         check($sformatf("rst_hold_noerr_c%0d", j), {err_residue_o, err_type_o}, 0);
      end
      step(0, 0, 0);
      step(1, 32'hEF21CDAB, 8'h2C);
      step(1, 32'h99884301, 8'h2C);
      check("post_rst_partial", output_valid_o, 0);
      step(0, 0, 0);
      check("post_rst_valid", output_valid_o, 1);
      check("post_rst_pixels", output_o, exp_raw12);
      step(0, 0, 0);
      check("post_rst_residue", err_residue_o, 1);
      step(0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
